// File: rtl/mem_seq_ctrl_pkg.sv
// Shared types and constants for the load/store memory sequencing controller:
// FSM state encoding, registered control-output bundle and default opcodes.
package mem_seq_ctrl_pkg;

  localparam logic [5:0] LW_OP_DEFAULT   = 6'b100011;
  localparam logic [5:0] SW_OP_DEFAULT   = 6'b101011;
  localparam int         TIMEOUT_DEFAULT = 15;
  localparam int         WAIT_W          = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ADDR,
    S_MEM,
    S_WB,
    S_ERR
  } state_e;

  typedef struct packed {
    logic ir_we;
    logic pc_we;
    logic alu_we;
    logic mem_req;
    logic mem_wr;
    logic reg_we;
    logic err;
  } ctrl_out_t;

  // Control strobes owned by a state; evaluated on the next state so they can be registered.
  function automatic ctrl_out_t state_outputs(state_e st, logic is_load, logic is_store);
    ctrl_out_t o;
    o = '0;
    case (st)
      S_FETCH: o.ir_we  = 1'b1;
      S_ADDR:  o.alu_we = 1'b1;
      S_MEM: begin
        o.mem_req = 1'b1;
        o.mem_wr  = is_store;
      end
      S_WB: begin
        o.pc_we  = 1'b1;
        o.reg_we = is_load;
      end
      S_ERR: begin
        o.pc_we = 1'b1;
        o.err   = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mem_seq_ctrl_timer.sv
// Wait counter for the MEM state; expired flags the cycle in which a still-unanswered
// request reaches TIMEOUT waited cycles.
module mem_wait_timer
  import mem_seq_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The increment in this cycle would make the count equal TIMEOUT.
  assign expired = enable && (count_q == LIMIT);

endmodule

// File: rtl/mem_seq_ctrl.sv
// Multi-cycle LW/SW sequencer: fetch, decode, address, memory handshake with timeout,
// write-back. All outputs are registered copies of the next-state decode.
module mem_seq_ctrl
  import mem_seq_ctrl_pkg::*;
#(
  parameter logic [5:0] LW_OP   = LW_OP_DEFAULT,
  parameter logic [5:0] SW_OP   = SW_OP_DEFAULT,
  parameter int         TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic        alu_we,
  output logic        mem_req,
  output logic        mem_wr,
  output logic        reg_we,
  output logic        err,
  output logic [15:0] retired
);

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  ctrl_out_t   out_q, out_d;
  logic [15:0] retired_q, retired_d;

  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  assign timer_clear = (state_q == S_ADDR);
  assign timer_en    = (state_q == S_MEM) && !mem_ready;

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d    = opcode;
        state_d = (opcode == LW_OP || opcode == SW_OP) ? S_ADDR : S_ERR;
      end
      S_ADDR:   state_d = S_MEM;
      S_MEM: begin
        // A ready strobe in the timeout cycle still wins.
        if (mem_ready) begin
          state_d = S_WB;
        end else if (timer_expired) begin
          state_d = S_ERR;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_ERR:    state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
    out_d     = state_outputs(state_d, op_d == LW_OP, op_d == SW_OP);
    retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      out_q   <= out_d;
    end
  end

  // Counts on entry to write-back so the new total is visible during WB; wraps freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (state_d == S_WB) begin
      retired_q <= retired_d;
    end
  end

  assign ir_we   = out_q.ir_we;
  assign pc_we   = out_q.pc_we;
  assign alu_we  = out_q.alu_we;
  assign mem_req = out_q.mem_req;
  assign mem_wr  = out_q.mem_wr;
  assign reg_we  = out_q.reg_we;
  assign err     = out_q.err;
  assign retired = retired_q;

endmodule

// File: doc/mem_seq_ctrl.md
MEM_SEQ_CTRL -- requirements
Module: mem_seq_ctrl

Interface
REQ-001 SHALL have parameter LW_OP, 6'b100011, load-word opcode.
REQ-002 SHALL have parameter SW_OP, 6'b101011, store-word opcode.
REQ-003 SHALL have parameter TIMEOUT, 15, max wait cycles for mem_ready (range 1..255).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port opcode  in  6  ins_out[31:26] of the current instruction register.
REQ-007 SHALL have port mem_ready  in  1  data memory done strobe, one cycle.
REQ-008 SHALL have port ir_we  out  1  instruction register load.
REQ-009 SHALL have port pc_we  out  1  PC advance (PC+4).
REQ-010 SHALL have port alu_we  out  1  latch ALU address result.
REQ-011 SHALL have port mem_req  out  1  data memory access request.
REQ-012 SHALL have port mem_wr  out  1  access is a write (ctrl2 equivalent); valid only with mem_req.
REQ-013 SHALL have port reg_we  out  1  register file write of memory read data (ctrl1 equivalent).
REQ-014 SHALL have port err  out  1  one-cycle flag: illegal opcode or memory timeout.
REQ-015 SHALL have port retired  out  16  count of completed LW/SW instructions.

Function
REQ-016 SHALL implement an FSM with states IDLE, FETCH, DECODE, ADDR, MEM, WB, ERR.
REQ-017 SHALL drive all outputs from registers (Moore); no combinational input-to-output path.
REQ-018 IDLE SHALL last one cycle after reset, then go to FETCH.
REQ-019 FETCH SHALL assert ir_we for one cycle, then go to DECODE.
REQ-020 DECODE SHALL go to ADDR if opcode equals LW_OP or SW_OP, else to ERR.
REQ-021 ADDR SHALL assert alu_we for one cycle, then go to MEM.
REQ-022 MEM SHALL hold mem_req=1 (mem_wr=1 for SW_OP, 0 for LW_OP) every cycle until mem_ready is sampled high, then go to WB.
REQ-023 The opcode SHALL be latched in DECODE; changes on opcode after DECODE SHALL NOT affect mem_wr or reg_we.
REQ-024 A wait counter SHALL clear on entry to MEM and increment each MEM cycle without mem_ready; at count == TIMEOUT without mem_ready the FSM SHALL go to ERR.
REQ-025 mem_ready in the same cycle the count reaches TIMEOUT SHALL take priority (go to WB, no err).
REQ-026 mem_ready outside MEM SHALL be ignored.
REQ-027 WB SHALL assert pc_we for one cycle, assert reg_we for one cycle only for LW, increment retired, then go to FETCH.
REQ-028 ERR SHALL assert err and pc_we for one cycle (skip instruction), not change retired, then go to FETCH.
REQ-029 retired SHALL wrap from 16'hFFFF to 16'h0000 without flagging.
REQ-030 Latency: LW/SW with mem_ready on first MEM cycle SHALL complete in 5 cycles FETCH..WB; each wait cycle adds one.
REQ-031 At most one of ir_we, alu_we, pc_we-without-err SHALL be high in any cycle.

Reset
REQ-032 rst SHALL take priority over all transitions, including mid-MEM; state returns to IDLE at the next edge.
REQ-033 On reset all outputs SHALL be 0, retired 16'h0000, wait counter 0, latched opcode 0.
REQ-034 An outstanding mem_req SHALL drop in the cycle after rst is sampled; no reg_we or pc_we for the aborted instruction.

Structure
REQ-035 The state encoding typedef, LW_OP/SW_OP opcode constants and the default TIMEOUT SHALL live in a shared package used by ctrl and the datapath top.
REQ-036 The wait counter plus timeout compare SHALL be one sub-module, mem_wait_timer (clear, enable, expired).
REQ-037 The FSM and retired counter SHALL stay in mem_seq_ctrl.

Verification
REQ-038 LW, mem_ready on first MEM cycle -> ir_we@1, alu_we@3, mem_req=1 mem_wr=0 @4, pc_we=reg_we=1 @5, retired=1.
REQ-039 SW, mem_ready after 3 wait cycles -> mem_req=1 mem_wr=1 for 4 cycles, reg_we never 1, pc_we once, retired=1.
REQ-040 opcode 6'b000000 in DECODE -> ERR: err=1 pc_we=1 one cycle, mem_req never 1, retired unchanged.
REQ-041 TIMEOUT=15, mem_ready never -> err=1 after 15 MEM cycles, mem_req drops, FSM back to FETCH; mem_ready on the 15th cycle -> WB, err=0.
REQ-042 rst asserted during 2nd MEM wait cycle -> next cycle all outputs 0, IDLE then FETCH, retired=0.
REQ-043 Preload retired=16'hFFFF via 65535 LW completions (or force) -> next completion gives 16'h0000, err=0.
